fdma_stream_writer: RTL and testbench
=====================================

# fdma_stream_writer

Stream-to-FDMA write front end. Accepts a valid/ready data stream, buffers it in an internal show-ahead FIFO, and drives the FDMA write-request port of the AXI DMA engine. It cuts the stream into chunk requests placed in a circular DDR buffer. It sits directly upstream of the DMA write channel and is its only write-side client.

## Interface
Parameters:
- ADDR_WIDTH, 32, byte-address width; matches the DMA M_AXI_ADDR_WIDTH.
- DATA_WIDTH, 128, word width; matches the DMA M_AXI_DATA_WIDTH. Multiple of 8.
- FIFO_DEPTH, 512, FIFO words. Power of two, ≥ 2×CHUNK_WORDS.
- CHUNK_WORDS, 256, maximum words per FDMA request. Range 1..FIFO_DEPTH/2.

Ports (reset is asynchronous and active-low; one clock):
- M_AXI_ACLK  in  1  clock
- M_AXI_ARESETN  in  1  async active-low reset
- enable  in  1  permits new requests; in-flight request always completes
- cfg_base_addr  in  ADDR_WIDTH  ring base, byte address, DATA_WIDTH/8 aligned
- cfg_buf_words  in  32  ring size in words, ≥1; sampled while IDLE
- s_data  in  DATA_WIDTH  stream word
- s_valid  in  1  stream valid
- s_ready  out  1  stream ready
- s_last  in  1  end-of-frame marker on the current word
- fdma_w_addr  out  ADDR_WIDTH  request byte address
- fdma_w_areq  out  1  request pulse, one cycle
- fdma_w_size  out  32  request word count
- fdma_w_busy  in  1  DMA write busy
- fdma_w_data  out  DATA_WIDTH  FIFO head word
- fdma_w_valid  in  1  DMA consumed fdma_w_data this cycle (pop)
- fdma_w_ready  out  1  FIFO non-empty
- chunk_done  out  1  one-cycle pulse when a request completes
- wrap  out  1  one-cycle pulse when the ring offset returns to 0

## Operation
- FIFO: push on s_valid&s_ready. Pop on fdma_w_valid. fdma_w_data is combinational mem[rd_ptr]. `count` is 0..FIFO_DEPTH (width log2(FIFO_DEPTH)+1). Simultaneous push and pop leaves count unchanged. s_ready = (count < FIFO_DEPTH) & ~flush_hold.
- fdma_w_valid while count==0 is a DMA protocol error. It is ignored: no pop, and pointers are unchanged.
- Ring state: `offset` (32 bit, words). Request address = cfg_base_addr + offset×(DATA_WIDTH/8), truncated to ADDR_WIDTH.
- Request size n = min(count, CHUNK_WORDS, cfg_buf_words − offset).
- FSM states:
  - IDLE → REQ when enable and either count ≥ min(CHUNK_WORDS, cfg_buf_words − offset), or (flush_hold and count>0).
  - REQ: fdma_w_areq=1 for exactly this cycle. fdma_w_addr and fdma_w_size are registered at entry and held until the next REQ. Next state is WAIT.
  - WAIT → XFER when fdma_w_busy==1.
  - XFER → DONE when fdma_w_busy==0.
  - DONE: chunk_done=1. offset += n; if the result equals cfg_buf_words, offset=0 and wrap=1. Next state is IDLE.
- The next request cannot issue before DONE. The DMA sees exactly n pops per request because the FIFO holds ≥ n words at issue.

## Timing
- Reset values: s_ready=0 while reset is asserted and 1 in the first cycle after release (FIFO empty). fdma_w_areq=0, fdma_w_addr=0, fdma_w_size=0, fdma_w_ready=0, chunk_done=0, wrap=0, offset=0, FSM=IDLE.
- Push-to-pop availability: a word pushed at edge k is visible on fdma_w_data and fdma_w_ready after edge k.
- Threshold-to-request: fdma_w_areq is asserted on the cycle after the IDLE condition is met.
- Request spacing is at least 4 cycles (REQ, WAIT, XFER, DONE) beyond the DMA transfer time.
- Reset mid-transfer: all state clears immediately and FIFO contents are discarded. The DMA is reset on the same reset net.
- enable deasserted in WAIT or XFER: the current request finishes; the FSM then stays in IDLE.

## Configuration
- FDMA_WR_FLUSH_EN defined:
  - A pushed word with s_last=1 sets flush_hold, which deasserts s_ready.
  - Partial chunks issue until count==0; a flush chunk also truncates at the ring end.
  - In the cycle count reaches 0, flush_hold clears and offset is forced to 0; wrap pulses if offset was nonzero. Each frame therefore starts at cfg_base_addr.
- Not defined: s_last is ignored, flush_hold stays 0, and only full-threshold requests issue.

## Test plan
- CHUNK_WORDS=256, cfg_buf_words=1024, base=0x1000_0000; stream 1024 words with the DMA model always ready → four requests at addresses 0x1000_0000, 0x1000_1000, 0x1000_2000, 0x1000_3000, size 256 each. wrap pulses once after the fourth chunk_done. Data arrives in order.
- cfg_buf_words=600; stream 1200 words → sizes 256, 256, 88, 256, 256, 88. The third request is at base+0x2000, and wrap pulses after requests 3 and 6.
- FIFO full: DMA model holds fdma_w_busy low (never accepts); stream 600 words → s_ready drops after 512 words accepted. Exactly one request (size 256) is pending in WAIT.
- FDMA_WR_FLUSH_EN: stream 300 words with s_last on word 300 → requests of 256 then 44. s_ready is low from the push of word 300 until the FIFO empties. The next frame starts at base.
- Assert reset during XFER after 100 pops → all outputs reach their reset values asynchronously. After release, a fresh 256-word stream issues at base with size 256.
- Deassert enable with 300 words buffered → no areq. Reassert → areq occurs on the cycle after the next IDLE evaluation, with size 256.

Source files
------------

// File: rtl/fdma_stream_writer_if.sv
`default_nettype none
// ============================================================================
// Module   : fdma_stream_writer_if
// Function : Stream input and FDMA write-request bundle for fdma_stream_writer.
// Revision : 1.0
// ============================================================================
interface fdma_stream_writer_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 128
);
  logic [DATA_WIDTH-1:0] s_data;
  logic                  s_valid;
  logic                  s_ready;
  logic                  s_last;
  logic [ADDR_WIDTH-1:0] fdma_w_addr;
  logic                  fdma_w_areq;
  logic [31:0]           fdma_w_size;
  logic                  fdma_w_busy;
  logic [DATA_WIDTH-1:0] fdma_w_data;
  logic                  fdma_w_valid;
  logic                  fdma_w_ready;

  // master: the stream writer itself
  modport master (
    input  s_data, s_valid, s_last, fdma_w_busy, fdma_w_valid,
    output s_ready, fdma_w_addr, fdma_w_areq, fdma_w_size, fdma_w_data, fdma_w_ready
  );

  // slave: stream source plus DMA write channel
  modport slave (
    output s_data, s_valid, s_last, fdma_w_busy, fdma_w_valid,
    input  s_ready, fdma_w_addr, fdma_w_areq, fdma_w_size, fdma_w_data, fdma_w_ready
  );
endinterface
`default_nettype wire

// File: rtl/fdma_stream_writer.sv
`default_nettype none
// ============================================================================
// Module   : fdma_stream_writer
// Function : Buffers a stream in a show-ahead FIFO and issues chunked FDMA
//            write requests into a circular DDR buffer. Optional end-of-frame
//            flush is enabled by defining FDMA_WR_FLUSH_EN.
// Revision : 1.0
// ============================================================================
module fdma_stream_writer #(
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 128,
  parameter int FIFO_DEPTH  = 512,
  parameter int CHUNK_WORDS = 256
) (
  input  logic                  M_AXI_ACLK,
  input  logic                  M_AXI_ARESETN,
  input  logic                  enable,
  input  logic [ADDR_WIDTH-1:0] cfg_base_addr,
  input  logic [31:0]           cfg_buf_words,
  fdma_stream_writer_if.master  bus,
  output logic                  chunk_done,
  output logic                  wrap
);

  localparam int                    c_ptr_w   = $clog2(FIFO_DEPTH);
  localparam int                    c_cnt_w   = c_ptr_w + 1;
  localparam logic [c_cnt_w-1:0]    c_depth   = c_cnt_w'(FIFO_DEPTH);
  localparam logic [31:0]           c_chunk   = 32'(CHUNK_WORDS);
  localparam logic [ADDR_WIDTH-1:0] c_bytes   = ADDR_WIDTH'(DATA_WIDTH / 8);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_REQ  = 3'd1,
    S_WAIT = 3'd2,
    S_XFER = 3'd3,
    S_DONE = 3'd4
  } state_t;

  logic [DATA_WIDTH-1:0] r_mem [FIFO_DEPTH];
  logic [c_ptr_w-1:0]    r_wr_ptr;
  logic [c_ptr_w-1:0]    r_rd_ptr;
  logic [c_cnt_w-1:0]    r_count;
  logic [c_cnt_w-1:0]    w_count_nxt;
  logic                  w_push;
  logic                  w_pop;
  logic                  w_flush_hold;

  state_t                r_state;
  logic [31:0]           r_offset;
  logic [31:0]           r_buf_words;
  logic [31:0]           r_size;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic                  r_areq;
  logic                  r_chunk_done;
  logic                  r_wrap;

  logic [31:0]           w_buf_words;
  logic [31:0]           w_remain;
  logic [31:0]           w_thresh;
  logic [31:0]           w_count32;
  logic [31:0]           w_req_size;
  logic [ADDR_WIDTH-1:0] w_req_addr;
  logic [31:0]           w_off_sum;
  logic                  w_start;
  logic                  w_xfer_end;
  logic                  w_ring_end;
  logic                  w_flush_end;

  // s_ready is gated by the reset net so it reads low throughout reset
  assign bus.s_ready      = M_AXI_ARESETN & (r_count < c_depth) & ~w_flush_hold;
  assign bus.fdma_w_ready = (r_count != '0);
  assign bus.fdma_w_data  = r_mem[r_rd_ptr];
  assign w_push           = bus.s_valid & bus.s_ready;
  assign w_pop            = bus.fdma_w_valid & (r_count != '0);

  always_comb begin
    w_count_nxt = r_count;
    if (w_push && !w_pop) begin
      w_count_nxt = r_count + c_cnt_w'(1);
    end else if (!w_push && w_pop) begin
      w_count_nxt = r_count - c_cnt_w'(1);
    end
  end

  always_ff @(posedge M_AXI_ACLK) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= bus.s_data;
    end
  end

  always_ff @(posedge M_AXI_ACLK or negedge M_AXI_ARESETN) begin
    if (!M_AXI_ARESETN) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + c_ptr_w'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + c_ptr_w'(1);
      end
      r_count <= w_count_nxt;
    end
  end

  // Ring size is taken live while idle and frozen for the request in flight
  assign w_buf_words = (r_state == S_IDLE) ? cfg_buf_words : r_buf_words;
  assign w_remain    = w_buf_words - r_offset;
  assign w_thresh    = (c_chunk < w_remain) ? c_chunk : w_remain;
  assign w_count32   = 32'(r_count);
  assign w_req_size  = (w_count32 < w_thresh) ? w_count32 : w_thresh;
  assign w_req_addr  = cfg_base_addr + ADDR_WIDTH'(r_offset) * c_bytes;
  assign w_start     = enable && (w_req_size != 32'd0) &&
                       ((w_count32 >= w_thresh) || (w_flush_hold && (r_count != '0)));
  assign w_xfer_end  = (r_state == S_XFER) && !bus.fdma_w_busy;
  assign w_off_sum   = r_offset + r_size;
  assign w_ring_end  = (w_off_sum == r_buf_words);
  assign w_flush_end = w_flush_hold && (w_count_nxt == '0);

`ifdef FDMA_WR_FLUSH_EN
  logic r_flush_hold;

  always_ff @(posedge M_AXI_ACLK or negedge M_AXI_ARESETN) begin
    if (!M_AXI_ARESETN) begin
      r_flush_hold <= 1'b0;
    end else if (w_push && bus.s_last) begin
      r_flush_hold <= 1'b1;
    end else if (w_xfer_end && (w_count_nxt == '0)) begin
      r_flush_hold <= 1'b0;
    end
  end

  assign w_flush_hold = r_flush_hold;
`else
  logic w_unused_last;

  assign w_flush_hold  = 1'b0;
  assign w_unused_last = bus.s_last;
`endif

  always_ff @(posedge M_AXI_ACLK or negedge M_AXI_ARESETN) begin
    if (!M_AXI_ARESETN) begin
      r_state      <= S_IDLE;
      r_offset     <= 32'd0;
      r_buf_words  <= 32'd0;
      r_size       <= 32'd0;
      r_addr       <= '0;
      r_areq       <= 1'b0;
      r_chunk_done <= 1'b0;
      r_wrap       <= 1'b0;
    end else begin
      r_areq       <= 1'b0;
      r_chunk_done <= 1'b0;
      r_wrap       <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_buf_words <= cfg_buf_words;
          if (w_start) begin
            r_state <= S_REQ;
            r_areq  <= 1'b1;
            r_addr  <= w_req_addr;
            r_size  <= w_req_size;
          end
        end
        S_REQ: begin
          r_state <= S_WAIT;
        end
        S_WAIT: begin
          if (bus.fdma_w_busy) begin
            r_state <= S_XFER;
          end
        end
        S_XFER: begin
          if (w_xfer_end) begin
            r_state      <= S_DONE;
            r_chunk_done <= 1'b1;
            // A finished frame restarts the ring; wrap reports any nonzero return
            if (w_ring_end || w_flush_end) begin
              r_offset <= 32'd0;
            end else begin
              r_offset <= w_off_sum;
            end
            r_wrap <= w_ring_end || (w_flush_end && (w_off_sum != 32'd0));
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.fdma_w_areq = r_areq;
  assign bus.fdma_w_addr = r_addr;
  assign bus.fdma_w_size = r_size;
  assign chunk_done      = r_chunk_done;
  assign wrap            = r_wrap;

endmodule
`default_nettype wire

// File: tb/tb_fdma_stream_writer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_fdma_stream_writer
// Function : Randomized stream and DMA model against a ring/request plan.
// Revision : 1.0
// ============================================================================
module tb_fdma_stream_writer;
  localparam int AW    = 32;
  localparam int DW    = 128;
  localparam int DEPTH = 512;
  localparam int CHUNK = 256;
  localparam logic [AW-1:0] BASE = 32'h1000_0000;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          enable;
  logic [AW-1:0] cfg_base_addr;
  logic [31:0]   cfg_buf_words;
  logic          chunk_done;
  logic          wrap;

  fdma_stream_writer_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  fdma_stream_writer #(
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW),
    .FIFO_DEPTH (DEPTH),
    .CHUNK_WORDS(CHUNK)
  ) dut (
    .M_AXI_ACLK   (clk),
    .M_AXI_ARESETN(rst_n),
    .enable       (enable),
    .cfg_base_addr(cfg_base_addr),
    .cfg_buf_words(cfg_buf_words),
    .bus          (bus),
    .chunk_done   (chunk_done),
    .wrap         (wrap)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] data_q[$];
  logic [AW-1:0] exp_addr_q[$];
  int            exp_size_q[$];
  bit            exp_wrap_q[$];
  int            m_off;
  int            n_areq, n_done, n_wrap, pops_total;
  int            dma_mode;  // 0: normal DMA, 1: never starts
  bit            prev_areq;

  // Expected request list from the ring rules: each chunk is
  // min(CHUNK, ring words left, frame words left when flushing)
  function automatic void plan(input int total, input bit flush);
    int left;
    int n;
    int b;
    bit wr;
    left = total;
    b    = int'(cfg_buf_words);
    while (left > 0) begin
      n = (CHUNK < (b - m_off)) ? CHUNK : (b - m_off);
      if (flush) begin
        if (left < n) n = left;
      end else if (left < n) begin
        break;
      end
      exp_addr_q.push_back(cfg_base_addr + AW'(m_off * (DW / 8)));
      exp_size_q.push_back(n);
      m_off += n;
      left  -= n;
      wr = 1'b0;
      if (m_off == b) begin
        m_off = 0;
        wr    = 1'b1;
      end
      if (flush && (left == 0) && (m_off != 0)) begin
        m_off = 0;
        wr    = 1'b1;
      end
      exp_wrap_q.push_back(wr);
    end
  endfunction

  // DMA write-channel model plus request/completion monitor
  initial begin : dma_model
    int phase;
    int rem;
    logic [DW-1:0] exp_w;
    phase = 0;
    rem   = 0;
    bus.fdma_w_busy  = 1'b0;
    bus.fdma_w_valid = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      bus.fdma_w_valid = 1'b0;
      if (!rst_n) begin
        bus.fdma_w_busy = 1'b0;
        phase     = 0;
        rem       = 0;
        prev_areq = 1'b0;
      end else begin
        if (bus.fdma_w_areq) begin
          n_areq++;
          checks++;
          if (prev_areq) begin
            errors++;
            $display("FAIL areq_pulse: areq high two cycles in a row, required one");
          end
          checks++;
          if (exp_addr_q.size() == 0) begin
            errors++;
            $display("FAIL areq_unexpected: addr %08h size %0d, required no request",
                     bus.fdma_w_addr, bus.fdma_w_size);
          end else begin
            if (bus.fdma_w_addr !== exp_addr_q[0] || bus.fdma_w_size !== 32'(exp_size_q[0])) begin
              errors++;
              $display("FAIL areq_fields: addr %08h size %0d, required addr %08h size %0d",
                       bus.fdma_w_addr, bus.fdma_w_size, exp_addr_q[0], exp_size_q[0]);
            end
            void'(exp_addr_q.pop_front());
            void'(exp_size_q.pop_front());
          end
          rem   = int'(bus.fdma_w_size);
          phase = (dma_mode == 0) ? 1 : 3;
        end else begin
          case (phase)
            1: begin
              bus.fdma_w_busy = 1'b1;
              phase = 2;
            end
            2: begin
              if (rem > 0) begin
                if (bus.fdma_w_ready && ($urandom_range(0, 3) != 0)) begin
                  bus.fdma_w_valid = 1'b1;
                  rem--;
                  pops_total++;
                  checks++;
                  if (data_q.size() == 0) begin
                    errors++;
                    $display("FAIL pop_data: got %h with nothing pushed", bus.fdma_w_data);
                  end else begin
                    exp_w = data_q.pop_front();
                    if (bus.fdma_w_data !== exp_w) begin
                      errors++;
                      $display("FAIL pop_data: got %h required %h", bus.fdma_w_data, exp_w);
                    end
                  end
                end
              end else begin
                bus.fdma_w_busy = 1'b0;
                phase = 0;
              end
            end
            default: ;
          endcase
        end
        prev_areq = bus.fdma_w_areq;

        if (wrap) n_wrap++;
        if (wrap && !chunk_done) begin
          checks++;
          errors++;
          $display("FAIL wrap_align: wrap pulsed without chunk_done");
        end
        if (chunk_done) begin
          n_done++;
          checks++;
          if (exp_wrap_q.size() == 0) begin
            errors++;
            $display("FAIL chunk_done_unexpected: chunk_done with no request planned");
          end else begin
            if (wrap !== exp_wrap_q[0]) begin
              errors++;
              $display("FAIL wrap_value: wrap %0b on chunk %0d, required %0b",
                       wrap, n_done, exp_wrap_q[0]);
            end
            void'(exp_wrap_q.pop_front());
          end
        end
      end
    end
  end

  task automatic do_reset();
    rst_n         = 1'b0;
    enable        = 1'b1;
    bus.s_valid   = 1'b0;
    bus.s_last    = 1'b0;
    repeat (3) @(posedge clk);
    #3;
    data_q.delete();
    exp_addr_q.delete();
    exp_size_q.delete();
    exp_wrap_q.delete();
    n_areq     = 0;
    n_done     = 0;
    n_wrap     = 0;
    pops_total = 0;
    m_off      = 0;
    dma_mode   = 0;
    rst_n      = 1'b1;
  endtask

  task automatic stream_words(input int n, input bit last_on_final, input int budget,
                              output int acc);
    int cyc;
    acc = 0;
    cyc = 0;
    @(posedge clk);
    #1;
    while (acc < n && cyc < budget) begin
      bus.s_valid = ($urandom_range(0, 3) != 0);
      bus.s_data  = {$urandom, $urandom, $urandom, $urandom};
      bus.s_last  = last_on_final && (acc == n - 1);
      if (bus.s_valid && bus.s_ready) begin
        data_q.push_back(bus.s_data);
        acc++;
      end
      @(posedge clk);
      #1;
      cyc++;
    end
    bus.s_valid = 1'b0;
    bus.s_last  = 1'b0;
  endtask

  task automatic wait_done(input int target, input int budget);
    for (int i = 0; i < budget && n_done < target; i++) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic test_reset();
    rst_n         = 1'b0;
    enable        = 1'b0;
    cfg_base_addr = BASE;
    cfg_buf_words = 32'd1024;
    bus.s_valid   = 1'b0;
    bus.s_last    = 1'b0;
    bus.s_data    = '0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (bus.s_ready !== 1'b0) begin
      errors++;
      $display("FAIL reset_s_ready: got %0b required 0", bus.s_ready);
    end
    checks++;
    if ({bus.fdma_w_areq, bus.fdma_w_ready, chunk_done, wrap} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_flags: areq/ready/done/wrap %04b required 0000",
               {bus.fdma_w_areq, bus.fdma_w_ready, chunk_done, wrap});
    end
    checks++;
    if (bus.fdma_w_addr !== '0 || bus.fdma_w_size !== 32'd0) begin
      errors++;
      $display("FAIL reset_req: addr %08h size %0d required 0/0", bus.fdma_w_addr, bus.fdma_w_size);
    end
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (bus.s_ready !== 1'b1 || bus.fdma_w_ready !== 1'b0) begin
      errors++;
      $display("FAIL release_ready: s_ready %0b w_ready %0b required 1/0",
               bus.s_ready, bus.fdma_w_ready);
    end
  endtask

  task automatic test_ring(input int buf_words, input int total, input int exp_chunks,
                           input int exp_wraps);
    int acc;
    do_reset();
    cfg_buf_words = 32'(buf_words);
    plan(total, 1'b0);
    stream_words(total, 1'b0, 20000, acc);
    checks++;
    if (acc !== total) begin
      errors++;
      $display("FAIL ring_accept: accepted %0d required %0d", acc, total);
    end
    wait_done(exp_chunks, 4000);
    repeat (5) @(posedge clk);
    #2;
    checks++;
    if (n_areq !== exp_chunks || n_done !== exp_chunks) begin
      errors++;
      $display("FAIL ring_chunks: areq %0d done %0d required %0d", n_areq, n_done, exp_chunks);
    end
    checks++;
    if (n_wrap !== exp_wraps) begin
      errors++;
      $display("FAIL ring_wraps: got %0d required %0d", n_wrap, exp_wraps);
    end
    checks++;
    if (data_q.size() !== 0 || exp_addr_q.size() !== 0) begin
      errors++;
      $display("FAIL ring_drain: words left %0d requests left %0d required 0/0",
               data_q.size(), exp_addr_q.size());
    end
  endtask

  task automatic test_fifo_full();
    int acc;
    do_reset();
    dma_mode      = 1;
    cfg_buf_words = 32'd1024;
    plan(256, 1'b0);
    stream_words(600, 1'b0, 1500, acc);
    repeat (20) @(posedge clk);
    #2;
    checks++;
    if (acc !== DEPTH) begin
      errors++;
      $display("FAIL full_accept: accepted %0d required %0d", acc, DEPTH);
    end
    checks++;
    if (bus.s_ready !== 1'b0 || bus.fdma_w_ready !== 1'b1) begin
      errors++;
      $display("FAIL full_ready: s_ready %0b w_ready %0b required 0/1", bus.s_ready, bus.fdma_w_ready);
    end
    checks++;
    if (n_areq !== 1 || n_done !== 0 || exp_addr_q.size() !== 0) begin
      errors++;
      $display("FAIL full_pending: areq %0d done %0d required 1/0", n_areq, n_done);
    end
  endtask

  task automatic test_reset_mid_xfer();
    int acc;
    do_reset();
    cfg_buf_words = 32'd1024;
    plan(256, 1'b0);
    stream_words(256, 1'b0, 2000, acc);
    for (int i = 0; i < 2000 && pops_total < 100; i++) begin
      @(posedge clk);
      #2;
    end
    checks++;
    if (pops_total < 100) begin
      errors++;
      $display("FAIL midreset_pops: got %0d pops required 100", pops_total);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({bus.s_ready, bus.fdma_w_areq, bus.fdma_w_ready, chunk_done, wrap} !== 5'b00000 ||
        bus.fdma_w_addr !== '0 || bus.fdma_w_size !== 32'd0) begin
      errors++;
      $display("FAIL midreset_async: rdy/areq/wrdy/done/wrap %05b addr %08h size %0d required zeros",
               {bus.s_ready, bus.fdma_w_areq, bus.fdma_w_ready, chunk_done, wrap},
               bus.fdma_w_addr, bus.fdma_w_size);
    end
    do_reset();
    cfg_buf_words = 32'd1024;
    plan(256, 1'b0);
    stream_words(256, 1'b0, 2000, acc);
    wait_done(1, 2000);
    checks++;
    if (n_areq !== 1 || n_done !== 1 || data_q.size() !== 0) begin
      errors++;
      $display("FAIL midreset_restart: areq %0d done %0d left %0d required 1/1/0",
               n_areq, n_done, data_q.size());
    end
  endtask

  task automatic test_enable();
    int acc;
    do_reset();
    enable        = 1'b0;
    cfg_buf_words = 32'd1024;
    stream_words(300, 1'b0, 2000, acc);
    repeat (20) @(posedge clk);
    #1;
    checks++;
    if (n_areq !== 0 || bus.fdma_w_areq !== 1'b0) begin
      errors++;
      $display("FAIL enable_off: areq count %0d required 0", n_areq);
    end
    plan(300, 1'b0);
    enable = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (bus.fdma_w_areq !== 1'b1 || bus.fdma_w_size !== 32'd256 || bus.fdma_w_addr !== BASE) begin
      errors++;
      $display("FAIL enable_latency: areq %0b size %0d addr %08h required 1/256/%08h",
               bus.fdma_w_areq, bus.fdma_w_size, bus.fdma_w_addr, BASE);
    end
    wait_done(1, 2000);
    repeat (5) @(posedge clk);
    #2;
    checks++;
    if (n_done !== 1 || data_q.size() !== 44) begin
      errors++;
      $display("FAIL enable_residue: done %0d left %0d required 1/44", n_done, data_q.size());
    end
  endtask

`ifdef FDMA_WR_FLUSH_EN
  task automatic test_flush();
    int acc;
    int viol;
    do_reset();
    cfg_buf_words = 32'd1024;
    plan(300, 1'b1);
    stream_words(300, 1'b1, 2000, acc);
    viol = 0;
    for (int i = 0; i < 2000 && n_done < 2; i++) begin
      if (bus.fdma_w_ready && bus.s_ready) viol++;
      @(posedge clk);
      #2;
    end
    checks++;
    if (viol !== 0) begin
      errors++;
      $display("FAIL flush_hold: s_ready high in %0d cycles with data buffered, required 0", viol);
    end
    repeat (3) @(posedge clk);
    #2;
    checks++;
    if (n_done !== 2 || n_wrap !== 1 || data_q.size() !== 0 || bus.s_ready !== 1'b1) begin
      errors++;
      $display("FAIL flush_frame: done %0d wraps %0d left %0d s_ready %0b required 2/1/0/1",
               n_done, n_wrap, data_q.size(), bus.s_ready);
    end
    plan(10, 1'b1);
    stream_words(10, 1'b1, 500, acc);
    wait_done(3, 1000);
    repeat (3) @(posedge clk);
    #2;
    checks++;
    if (n_done !== 3 || exp_addr_q.size() !== 0 || data_q.size() !== 0) begin
      errors++;
      $display("FAIL flush_next_frame: done %0d requests left %0d required 3/0",
               n_done, exp_addr_q.size());
    end
  endtask
`endif

  initial begin
    test_reset();
    test_ring(1024, 1024, 4, 1);
    test_ring(600, 1200, 6, 2);
    test_fifo_full();
    test_reset_mid_xfer();
    test_enable();
`ifdef FDMA_WR_FLUSH_EN
    test_flush();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
`default_nettype wire
